instruction_fetch_unit: RTL and testbench

Fetch stage of the 5-stage RISC-V pipeline. It owns the program counter, issues read requests to the instruction cache and absorbs cache-busy cycles, including OS-initiated cache switches. It applies branch/jump redirects and produces the registered IF/ID outputs (instruction, PC, valid) consumed by `instruction_decode_unit`. A one-entry skid buffer catches a response that arrives while decode is stalled, so no fetched word is lost or refetched.

---
 rtl/instruction_fetch_unit.sv | 126 ++++++++++++
 tb/tb_instruction_fetch_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//   IF stage of the 5-stage RISC-V pipeline. Owns the PC, requests words from
//   the instruction cache, rides out busy cycles, applies redirects from
//   execute and drives the registered IF/ID slot. A one-entry skid buffer
//   holds a word that lands while decode is stalled.
// Ports
//   clk, reset            : rising-edge clock, async active-low reset
//   stall                 : decode hazard hold, IF/ID frozen while high
//   branch_jump_taken,
//   branch_target         : redirect request/target from execute
//   i_mem_read/address    : cache request (address stable while busy)
//   i_mem_readdata/busy   : cache response / not-yet-accepted
//   instruction_out, pc_out, pc_plus4_out, instr_valid : IF/ID slot
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_jump_taken,
  input  logic [31:0] branch_target,
  output logic        i_mem_read,
  output logic [31:0] i_mem_address,
  input  logic [31:0] i_mem_readdata,
  input  logic        i_mem_busy,
  output logic [31:0] instruction_out,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4_out,
  output logic        instr_valid
);

  typedef enum logic {FETCH, DISCARD} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
  } ifid_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  ifid_t       ifid_q, ifid_d;
  logic        accept;

  // No request while the skid holds a word; in DISCARD the old request is
  // kept up so the cache sees a stable address until it finishes.
  assign i_mem_read    = reset & (((state_q == FETCH) & ~skid_valid_q) | (state_q == DISCARD));
  assign i_mem_address = fetch_pc_q;
  assign accept        = i_mem_read & ~i_mem_busy;

  assign instruction_out = ifid_q.instr;
  assign pc_out          = ifid_q.pc;
  assign instr_valid     = ifid_q.valid;
  assign pc_plus4_out    = ifid_q.pc + 32'd4;

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    redirect_pc_d = redirect_pc_q;
    skid_valid_d  = skid_valid_q;
    skid_instr_d  = skid_instr_q;
    skid_pc_d     = skid_pc_q;
    ifid_d        = ifid_q;

    if (branch_jump_taken) begin
      // Redirect beats stall; anything accepted this cycle is dropped.
      ifid_d.valid = 1'b0;
      ifid_d.instr = NOP_INSTR;
      skid_valid_d = 1'b0;
      if (i_mem_read & i_mem_busy) begin
        redirect_pc_d = branch_target;
        state_d       = DISCARD;
      end else begin
        fetch_pc_d = branch_target;
        state_d    = FETCH;
      end
    end else if (state_q == DISCARD) begin
      ifid_d.valid = 1'b0;
      ifid_d.instr = NOP_INSTR;
      if (~i_mem_busy) begin
        fetch_pc_d = redirect_pc_q;
        state_d    = FETCH;
      end
    end else if (accept & ~stall) begin
      ifid_d     = '{instr: i_mem_readdata, pc: fetch_pc_q, valid: 1'b1};
      fetch_pc_d = fetch_pc_q + 32'd4;
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_instr_d = i_mem_readdata;
      skid_pc_d    = fetch_pc_q;
      fetch_pc_d   = fetch_pc_q + 32'd4;
    end else if (~stall & skid_valid_q) begin
      ifid_d       = '{instr: skid_instr_q, pc: skid_pc_q, valid: 1'b1};
      skid_valid_d = 1'b0;
    end else if (~stall) begin
      ifid_d.valid = 1'b0;
      ifid_d.instr = NOP_INSTR;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= FETCH;
      fetch_pc_q    <= RESET_PC;
      redirect_pc_q <= '0;
      skid_valid_q  <= 1'b0;
      skid_instr_q  <= '0;
      skid_pc_q     <= '0;
      ifid_q        <= '{instr: NOP_INSTR, pc: 32'd0, valid: 1'b0};
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      redirect_pc_q <= redirect_pc_d;
      skid_valid_q  <= skid_valid_d;
      skid_instr_q  <= skid_instr_d;
      skid_pc_q     <= skid_pc_d;
      ifid_q        <= ifid_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        branch_jump_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        i_mem_read;
  logic [31:0] i_mem_address;
  logic [31:0] i_mem_readdata;
  logic        i_mem_busy = 1'b0;
  logic [31:0] instruction_out, pc_out, pc_plus4_out;
  logic        instr_valid;

  int checks = 0;
  int errors = 0;

  instruction_fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall),
    .branch_jump_taken(branch_jump_taken), .branch_target(branch_target),
    .i_mem_read(i_mem_read), .i_mem_address(i_mem_address),
    .i_mem_readdata(i_mem_readdata), .i_mem_busy(i_mem_busy),
    .instruction_out(instruction_out), .pc_out(pc_out),
    .pc_plus4_out(pc_plus4_out), .instr_valid(instr_valid)
  );

  always #5 clk = ~clk;

  // Cache returns words tagged with their address.
  function automatic logic [31:0] tag(input logic [31:0] a);
    return a ^ 32'hA500_0000;
  endfunction
  assign i_mem_readdata = tag(i_mem_address);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: fetched words enter a FIFO in address order; decode pops one per
  // unstalled cycle. A redirect empties the FIFO; a redirect while the cache
  // is busy waits for the stale word to drain before moving the address.
  bit          m_valid, m_disc;
  logic [31:0] m_pc, m_next, m_tgt;
  logic [31:0] m_q[$];

  function automatic bit m_req();
    return reset && (m_disc || m_q.size() == 0);
  endfunction

  initial begin
    m_valid = 0; m_disc = 0; m_pc = 0; m_next = 0; m_tgt = 0; m_q.delete();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_valid = 0; m_disc = 0; m_pc = 0; m_next = 0; m_q.delete();
      end else begin
        bit req;
        req = m_req();
        if (branch_jump_taken) begin
          m_valid = 0;
          m_q.delete();
          if (req && i_mem_busy) begin m_disc = 1; m_tgt = branch_target; end
          else begin m_disc = 0; m_next = branch_target; end
        end else if (m_disc) begin
          m_valid = 0;
          if (!i_mem_busy) begin m_disc = 0; m_next = m_tgt; end
        end else begin
          if (req && !i_mem_busy) begin m_q.push_back(m_next); m_next += 32'd4; end
          if (!stall) begin
            if (m_q.size() > 0) begin m_pc = m_q.pop_front(); m_valid = 1; end
            else m_valid = 0;
          end
        end
      end
    end
  end

  // Compare every cycle, on the falling edge.
  initial forever begin
    @(negedge clk);
    chk("m_read",  {31'd0, i_mem_read}, {31'd0, m_req()});
    chk("m_addr",  i_mem_address, m_next);
    chk("m_valid", {31'd0, instr_valid}, {31'd0, m_valid});
    chk("m_instr", instruction_out, m_valid ? tag(m_pc) : NOP);
    chk("m_pc",    pc_out, m_pc);
    chk("m_pc4",   pc_plus4_out, m_pc + 32'd4);
  end

  task automatic step(input logic s, input logic b, input logic [31:0] t, input logic bz);
    stall = s; branch_jump_taken = b; branch_target = t; i_mem_busy = bz;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk(name, act, exp);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    lit("rst_valid", {31'd0, instr_valid}, 32'd0);
    lit("rst_instr", instruction_out, NOP);
    lit("rst_pc", pc_out, 32'd0);
    lit("rst_pc4", pc_plus4_out, 32'd4);
    lit("rst_read", {31'd0, i_mem_read}, 32'd0);
    reset = 1'b1;
    #1;
    lit("first_read", {31'd0, i_mem_read}, 32'd1);
    lit("first_addr", i_mem_address, 32'h0);

    // Zero-wait streaming
    step(0, 0, 0, 0); lit("s0_pc", pc_out, 32'h0); lit("s0_v", {31'd0, instr_valid}, 32'd1);
    lit("s0_instr", instruction_out, 32'hA500_0000);
    step(0, 0, 0, 0); lit("s1_pc", pc_out, 32'h4); lit("s1_pc4", pc_plus4_out, 32'h8);

    // Busy three cycles at 0x8
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1);
      lit("busy_addr", i_mem_address, 32'h8);
      lit("busy_v", {31'd0, instr_valid}, 32'd0);
    end
    step(0, 0, 0, 0); lit("busy_done_pc", pc_out, 32'h8);

    // Stall while 0x10 returns
    step(0, 0, 0, 0); lit("pre_stall_pc", pc_out, 32'hC);
    step(1, 0, 0, 0); lit("stall_hold_pc", pc_out, 32'hC); lit("skid_read", {31'd0, i_mem_read}, 32'd0);
    step(1, 0, 0, 0); lit("stall_hold2_pc", pc_out, 32'hC);
    step(0, 0, 0, 0); lit("release_pc", pc_out, 32'h10); lit("release_read", {31'd0, i_mem_read}, 32'd1);
    step(0, 0, 0, 0); lit("after_release_pc", pc_out, 32'h14);

    // Redirect to 0x100 while busy on 0x20
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    lit("pre_redir_addr", i_mem_address, 32'h20);
    step(0, 0, 0, 1);
    step(0, 1, 32'h100, 1); lit("disc_addr", i_mem_address, 32'h20); lit("disc_v", {31'd0, instr_valid}, 32'd0);
    step(0, 0, 0, 1); lit("disc_addr2", i_mem_address, 32'h20);
    step(0, 0, 0, 0); lit("disc_end_addr", i_mem_address, 32'h100); lit("disc_end_v", {31'd0, instr_valid}, 32'd0);
    step(0, 0, 0, 0); lit("tgt_pc", pc_out, 32'h100);

    // Idle-cache redirect: one bubble
    step(0, 1, 32'h200, 0); lit("idle_redir_v", {31'd0, instr_valid}, 32'd0); lit("idle_redir_addr", i_mem_address, 32'h200);
    step(0, 0, 0, 0); lit("idle_tgt_pc", pc_out, 32'h200);

    // Redirect + stall with skid full
    step(1, 0, 0, 0); lit("skid_full_read", {31'd0, i_mem_read}, 32'd0);
    step(1, 1, 32'h300, 0); lit("rs_v", {31'd0, instr_valid}, 32'd0); lit("rs_read", {31'd0, i_mem_read}, 32'd1);
    step(0, 0, 0, 0); lit("rs_pc", pc_out, 32'h300);

    // Redirect overwritten while discarding
    step(0, 0, 0, 1);
    step(0, 1, 32'h400, 1);
    step(0, 1, 32'h500, 1);
    step(0, 0, 0, 0); lit("ovr_addr", i_mem_address, 32'h500);
    step(0, 0, 0, 0); lit("ovr_pc", pc_out, 32'h500);

    // Address wrap
    step(0, 1, 32'hFFFF_FFFC, 0);
    step(0, 0, 0, 0); lit("wrap_pc", pc_out, 32'hFFFF_FFFC); lit("wrap_pc4", pc_plus4_out, 32'h0);
    lit("wrap_addr", i_mem_address, 32'h0);
    step(0, 0, 0, 0); lit("wrap_next_pc", pc_out, 32'h0);

    // Misaligned target passes through
    step(0, 1, 32'h602, 0);
    step(0, 0, 0, 0); lit("mis_pc", pc_out, 32'h602);

    // Mixed stall/busy pattern with redirects
    for (int i = 0; i < 40; i++)
      step(i % 3 == 1, i == 20 || i == 27, (i == 20) ? 32'h700 : 32'h800, i % 5 == 2);

    // Reset mid-miss
    step(0, 0, 0, 1);
    #2 reset = 1'b0;
    #1;
    lit("arst_valid", {31'd0, instr_valid}, 32'd0);
    lit("arst_instr", instruction_out, NOP);
    lit("arst_pc", pc_out, 32'd0);
    lit("arst_read", {31'd0, i_mem_read}, 32'd0);
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    lit("rerun_addr", i_mem_address, 32'h0);
    step(0, 0, 0, 0); lit("rerun_pc", pc_out, 32'h0); lit("rerun_v", {31'd0, instr_valid}, 32'd1);
    step(0, 0, 0, 0); lit("rerun_pc2", pc_out, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
